// File: rtl/jk_bank_ctrl.sv
// -----------------------------------------------------------------------------
// jk_bank_ctrl
//
// Purpose:
//   Command-driven sequencer for a bank of WIDTH JK flip-flop cells. The cells
//   are plain jkff instances (posedge clk, synchronous pr/clr, pr over clr).
//   All behaviour lives here: clear, preset, parallel load, toggle-mask, hold
//   and multi-step synchronous up/down counting. The counting J/K terms are
//   formed combinationally from the bank's Q outputs, giving one step per clk.
//
// Optional feature macro: JKB_SAT_EN
//   Defined   : COUNT_UP stops at all ones, COUNT_DOWN stops at zero. A stop
//               ends EXEC early and raises sat, which stays set until the
//               next command is accepted.
//   Undefined : counting wraps modulo 2^WIDTH and sat is tied low.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   clr        in   1      asynchronous reset, active-high
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      controller can accept a command (IDLE only)
//   cmd_op     in   3      opcode
//   cmd_data   in   WIDTH  load value / toggle mask
//   cmd_len    in   CNT_W  step count for COUNT_UP / COUNT_DOWN / HOLD
//   q_i        in   WIDTH  Q outputs of the bank
//   j_o        out  WIDTH  J inputs to the bank
//   k_o        out  WIDTH  K inputs to the bank
//   pr_o       out  WIDTH  preset inputs to the bank
//   clr_o      out  WIDTH  clear inputs to the bank
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle completion pulse (DONE state)
//   sat        out  1      saturation flag (JKB_SAT_EN only, else 0)
//   dbg_state  out  2      current FSM state (INIT=0 IDLE=1 EXEC=2 DONE=3)
//
// Handshake:
//   A command transfers on a rising clk edge where cmd_valid && cmd_ready.
//   cmd_ready is high only in IDLE; the source holds cmd_valid and the
//   command fields stable until the transfer, and a command presented while
//   busy is simply not taken.
// -----------------------------------------------------------------------------
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] pr_o,
  output logic [WIDTH-1:0] clr_o,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_PRESET = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;
  localparam logic [2:0] OP_TOGGLE = 3'b110;
  localparam logic [2:0] OP_HOLD   = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_multi;
  logic [WIDTH-1:0] w_up_en;
  logic [WIDTH-1:0] w_dn_en;

  assign dbg_state = r_state;
  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_multi   = (cmd_op == OP_UP) || (cmd_op == OP_DOWN) || (cmd_op == OP_HOLD);

  // Ripple-carry toggle enables: bit i toggles when every lower bit is 1
  // (counting up) or every lower bit is 0 (counting down).
  always_comb begin
    logic c_up;
    logic c_dn;
    c_up = 1'b1;
    c_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_up_en[i] = c_up;
      w_dn_en[i] = c_dn;
      c_up       = c_up & q_i[i];
      c_dn       = c_dn & ~q_i[i];
    end
  end

`ifdef JKB_SAT_EN
  logic r_sat;
  logic w_stop;

  // Evaluated against the Q value present at the start of the EXEC cycle.
  assign w_stop = (r_state == ST_EXEC) &&
                  (((r_op == OP_UP)   && (q_i == {WIDTH{1'b1}})) ||
                   ((r_op == OP_DOWN) && (q_i == {WIDTH{1'b0}})));
  assign sat = r_sat;
`else
  assign sat = 1'b0;
`endif

  // State register and command latches.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_INIT;
      r_op    <= OP_NOP;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        // Single-cycle opcodes run exactly one EXEC step.
        r_cnt  <= w_multi ? cmd_len : CNT_W'(1);
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

`ifdef JKB_SAT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= 1'b0;
    end else if (w_stop) begin
      r_sat <= 1'b1;
    end
  end
`endif

  // Next-state and bank-control decode.
  always_comb begin
    w_next    = r_state;
    j_o       = '0;
    k_o       = '0;
    pr_o      = '0;
    clr_o     = '0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (r_state)
      ST_INIT: begin
        // Hold the bank clear request off while reset is still asserted so
        // the controls read zero for the whole reset interval.
        clr_o  = clr ? '0 : '1;
        w_next = ST_IDLE;
      end

      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (w_accept) begin
          // A zero-length multi-step command never touches the bank.
          w_next = (w_multi && (cmd_len == '0)) ? ST_DONE : ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (r_op)
          OP_NOP:    ;
          OP_CLEAR:  clr_o = '1;
          OP_PRESET: pr_o  = '1;
          OP_LOAD: begin
            j_o = r_data;
            k_o = ~r_data;
          end
          OP_UP: begin
            j_o = w_up_en;
            k_o = w_up_en;
          end
          OP_DOWN: begin
            j_o = w_dn_en;
            k_o = w_dn_en;
          end
          OP_TOGGLE: begin
            j_o = r_data;
            k_o = r_data;
          end
          OP_HOLD:   ;
          default:   ;
        endcase
`ifdef JKB_SAT_EN
        if (w_stop) begin
          j_o    = '0;
          k_o    = '0;
          w_next = ST_DONE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next = ST_DONE;
        end
`else
        if (r_cnt == CNT_W'(1)) begin
          w_next = ST_DONE;
        end
`endif
      end

      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end

      default: w_next = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
module tb_jk_bank_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int EW    = 17;  // {sat, latency[11:0], q[3:0]}

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_PRESET = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;
  localparam logic [2:0] OP_TOGGLE = 3'b110;
  localparam logic [2:0] OP_HOLD   = 3'b111;

  logic             clk;
  logic             clr;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] q_i;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;
  logic [WIDTH-1:0] pr_o;
  logic [WIDTH-1:0] clr_o;
  logic             busy;
  logic             done;
  logic             sat;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q_i       (q_i),
    .j_o       (j_o),
    .k_o       (k_o),
    .pr_o      (pr_o),
    .clr_o     (clr_o),
    .busy      (busy),
    .done      (done),
    .sat       (sat),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bank of jkff cells ----------------
  // Non-zero power-up value so the INIT clear is observable.
  initial q_i = 4'b0110;

  always @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (pr_o[i])       q_i[i] <= 1'b1;
      else if (clr_o[i]) q_i[i] <= 1'b0;
      else begin
        case ({j_o[i], k_o[i]})
          2'b01:   q_i[i] <= 1'b0;
          2'b10:   q_i[i] <= 1'b1;
          2'b11:   q_i[i] <= ~q_i[i];
          default: q_i[i] <= q_i[i];
        endcase
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] data,
                          input logic [7:0] len, input logic [3:0] eq,
                          input int elat, input logic esat, input bit push);
    bit taken;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    if (push) exp_q.push_back({esat, 12'(elat), eq});
    taken = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0h not accepted", op);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: controller never returned to IDLE");
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data,
                         input logic [7:0] len, input logic [3:0] eq,
                         input int elat, input logic esat);
    send_cmd(op, data, len, eq, elat, esat, 1'b1);
    wait_idle();
  endtask

  // ---------------- scoreboard monitor ----------------
  bit trk = 1'b0;
  int cyc = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (clr) begin
      trk = 1'b0;
    end else begin
      if (trk) cyc++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done with empty queue, q=%0h", q_i);
        end else begin
          e = exp_q.pop_front();
          chk("done_q",   32'(q_i), 32'(e[3:0]));
          chk("done_lat", 32'(cyc), 32'(e[15:4]));
          chk("done_sat", 32'(sat), 32'(e[16]));
        end
        trk = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        trk = 1'b1;
        cyc = 0;
      end
    end
  end

  // Bank control exclusivity, every cycle outside reset.
  always @(negedge clk) begin
    if (!clr) begin
      chk("pr_clr_excl", 32'((pr_o != '0) && (clr_o != '0)), 32'd0);
      chk("jk_quiet",    32'(((pr_o | clr_o) != '0) && ((j_o | k_o) != '0)), 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    clr       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    cmd_len   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_j",     32'(j_o), 32'd0);
    chk("rst_k",     32'(k_o), 32'd0);
    chk("rst_pr",    32'(pr_o), 32'd0);
    chk("rst_clr_o", 32'(clr_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_sat",   32'(sat), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // 1. Reset release: one INIT cycle clearing the bank, then IDLE
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("init_clr_o",  32'(clr_o), 32'hF);
    chk("init_busy",   32'(busy), 32'd1);
    chk("init_ready",  32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("idle_ready",  32'(cmd_ready), 32'd1);
    chk("idle_busy",   32'(busy), 32'd0);
    chk("idle_clr_o",  32'(clr_o), 32'd0);
    chk("idle_q",      32'(q_i), 32'd0);

    // 2. LOAD 1010
    send_cmd(OP_LOAD, 4'b1010, 8'd0, 4'b1010, 2, 1'b0, 1'b1);
    @(negedge clk);
    chk("load_j", 32'(j_o), 32'b1010);
    chk("load_k", 32'(k_o), 32'b0101);
    wait_idle();

    // 3. LOAD 0000, COUNT_UP len=5
    run_cmd(OP_LOAD, 4'b0000, 8'd0, 4'b0000, 2, 1'b0);
    send_cmd(OP_UP, 4'b0000, 8'd5, 4'b0101, 6, 1'b0, 1'b1);
    @(negedge clk);
    chk("up_j0", 32'(j_o), 32'b0001);
    chk("up_k0", 32'(k_o), 32'b0001);
    @(negedge clk);
    chk("up_q1", 32'(q_i), 32'd1);
    chk("up_j1", 32'(j_o), 32'b0011);
    @(negedge clk);
    chk("up_q2", 32'(q_i), 32'd2);
    @(negedge clk);
    chk("up_q3", 32'(q_i), 32'd3);
    chk("up_j3", 32'(j_o), 32'b0111);
    wait_idle();

    // 4. LOAD 0001, COUNT_DOWN len=3
    run_cmd(OP_LOAD, 4'b0001, 8'd0, 4'b0001, 2, 1'b0);
`ifdef JKB_SAT_EN
    send_cmd(OP_DOWN, 4'b0000, 8'd3, 4'b0000, 3, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("dn_q1",    32'(q_i), 32'd0);
    chk("dn_stopj", 32'(j_o), 32'd0);
    wait_idle();
    chk("sat_sticky", 32'(sat), 32'd1);
`else
    send_cmd(OP_DOWN, 4'b0000, 8'd3, 4'b1110, 4, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("dn_q1",   32'(q_i), 32'd0);
    chk("dn_wrapj", 32'(j_o), 32'b1111);
    @(negedge clk);
    chk("dn_q2",   32'(q_i), 32'b1111);
    wait_idle();
    chk("sat_tied", 32'(sat), 32'd0);
`endif

    // 5. TOGGLE, PRESET, HOLD, CLEAR, NOP
    run_cmd(OP_LOAD, 4'b1010, 8'd0, 4'b1010, 2, 1'b0);
    send_cmd(OP_TOGGLE, 4'b0110, 8'd0, 4'b1100, 2, 1'b0, 1'b1);
    @(negedge clk);
    chk("tog_j", 32'(j_o), 32'b0110);
    chk("tog_k", 32'(k_o), 32'b0110);
    wait_idle();
    send_cmd(OP_PRESET, 4'b0000, 8'd0, 4'b1111, 2, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_pr",  32'(pr_o), 32'b1111);
    chk("pre_clr", 32'(clr_o), 32'd0);
    wait_idle();
    run_cmd(OP_HOLD,  4'b0000, 8'd0, 4'b1111, 1, 1'b0);
    run_cmd(OP_HOLD,  4'b0101, 8'd3, 4'b1111, 4, 1'b0);
    send_cmd(OP_CLEAR, 4'b0000, 8'd0, 4'b0000, 2, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_clr_o", 32'(clr_o), 32'b1111);
    wait_idle();
    run_cmd(OP_NOP,   4'b1111, 8'd0, 4'b0000, 2, 1'b0);
    run_cmd(OP_UP,    4'b0000, 8'd0, 4'b0000, 1, 1'b0);

    // Counting up through the top
    run_cmd(OP_LOAD, 4'b1110, 8'd0, 4'b1110, 2, 1'b0);
`ifdef JKB_SAT_EN
    run_cmd(OP_UP, 4'b0000, 8'd3, 4'b1111, 3, 1'b1);
`else
    run_cmd(OP_UP, 4'b0000, 8'd3, 4'b0001, 4, 1'b0);
`endif

    // 6. Reset in the middle of a long COUNT_UP; command held while busy
    run_cmd(OP_LOAD, 4'b0000, 8'd0, 4'b0000, 2, 1'b0);
    send_cmd(OP_UP, 4'b0000, 8'd200, 4'b0000, 0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 4'b1001;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      chk("busy_ready", 32'(cmd_ready), 32'd0);
      chk("busy_q",     32'(q_i), 32'(s));
    end
    @(posedge clk); #1;
    clr       = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_q",     32'(q_i), 32'd10);
    chk("abort_j",     32'(j_o), 32'd0);
    chk("abort_k",     32'(k_o), 32'd0);
    chk("abort_pr",    32'(pr_o), 32'd0);
    chk("abort_clr_o", 32'(clr_o), 32'd0);
    chk("abort_busy",  32'(busy), 32'd1);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("reinit_clr_o", 32'(clr_o), 32'hF);
    chk("reinit_busy",  32'(busy), 32'd1);
    chk("reinit_j",     32'(j_o), 32'd0);
    @(negedge clk);
    chk("reidle_ready", 32'(cmd_ready), 32'd1);
    chk("reidle_q",     32'(q_i), 32'd0);

    run_cmd(OP_LOAD, 4'b0011, 8'd0, 4'b0011, 2, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
Command-driven sequencer for a bank of WIDTH jkff cells (posedge clk; synchronous pr/clr; pr has priority over clr).
- Accepts one command at a time over a valid/ready handshake.
- Drives per-bit J/K/pr/clr to the bank and reads the bank's Q outputs back.
- Implements clear, preset, parallel load, toggle-mask, hold and multi-step synchronous up/down counting with no logic inside the cells.
- Sits between the lab-level command source and the jkff instance array.

Parameters:
WIDTH, 4, number of jkff cells in the bank
CNT_W, 8, width of step/cycle count field

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  3  opcode
cmd_data  in  WIDTH  load value / toggle mask
cmd_len  in  CNT_W  step count for COUNT_UP/COUNT_DOWN/HOLD
q_i  in  WIDTH  Q outputs of bank
j_o  out  WIDTH  J inputs to bank
k_o  out  WIDTH  K inputs to bank
pr_o  out  WIDTH  preset inputs to bank
clr_o  out  WIDTH  clear inputs to bank
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
sat  out  1  saturation flag (only with JKB_SAT_EN; otherwise tied 0)

Behaviour:
- Reset (clr high, asynchronous):
  - state=INIT; j_o=k_o=pr_o=clr_o=0; done=0; sat=0; cmd_ready=0; counters=0.
- States: INIT, IDLE, EXEC, DONE.
  - INIT: first cycle after reset release; clr_o=all ones for exactly one cycle -> IDLE.
  - IDLE: cmd_ready=1; all bank controls 0.
    - On cmd_valid&&cmd_ready: latch op/data/len -> EXEC.
    - Accept is the only way to leave IDLE.
  - EXEC: bank controls per opcode; remaining-count register decrements each cycle.
    - Exit to DONE when the last step is driven.
    - Single-cycle ops spend exactly 1 cycle in EXEC.
  - DONE: controls 0; done=1 for one cycle; bank Q is final -> IDLE.
- Opcodes (controls driven during EXEC):
  - 000 NOP: all 0, 1 cycle.
  - 001 CLEAR: clr_o=all ones, 1 cycle.
  - 010 PRESET: pr_o=all ones, 1 cycle.
  - 011 LOAD: j_o=data, k_o=~data, 1 cycle.
  - 100 COUNT_UP: len cycles.
    - bit0: J=K=1.
    - bit i: J=K=AND(q_i[i-1:0]).
    - Combinational from q_i, so one increment per clk.
  - 101 COUNT_DOWN: len cycles; J=K=AND(~q_i[i-1:0]), bit0=1.
  - 110 TOGGLE: j_o=k_o=data, 1 cycle.
  - 111 HOLD: j_o=k_o=0 for len cycles.
- len=0 for COUNT_UP/COUNT_DOWN/HOLD: EXEC lasts 0 cycles; IDLE->DONE directly; bank untouched.
- Latency:
  - Single-cycle op: accept edge -> EXEC (1 cycle) -> DONE.
  - done asserts 2 cycles after the accept edge.
  - Multi-step op: done asserts len+1 cycles after the accept edge.
- Wrap-around: counting is modulo 2^WIDTH (1111 up -> 0000; 0000 down -> 1111).
- pr_o and clr_o are never both nonzero in the same cycle; j_o/k_o are 0 whenever pr_o or clr_o is nonzero.
- Commands presented while busy are ignored (cmd_ready=0); the source holds cmd_valid.
- Reset mid-operation: immediate abort to INIT; controls 0 asynchronously; bank cleared in the INIT cycle.
- Widths: count register CNT_W bits, no overflow since it only decrements from len.

Optional Feature:
JKB_SAT_EN
- Defined:
  - COUNT_UP stops when q_i==all ones and COUNT_DOWN stops when q_i==0, checked at the start of each EXEC cycle.
  - On a stop: j_o=k_o=0 that cycle, immediate transition to DONE, sat=1 with done.
  - sat clears on the next accept.
- Undefined: counting wraps as above; sat tied 0; no saturation comparator logic.

Test Plan:
1. Release reset -> clr_o=1111 in the first cycle, then IDLE with cmd_ready=1; bank Q=0000.
2. LOAD data=1010 -> j_o=1010, k_o=0101 for 1 cycle; done 2 cycles after accept; q_i=1010.
3. After LOAD 0000, COUNT_UP len=5 -> q_i steps 0001..0101 on successive clks; done at accept+6.
4. LOAD 0001, COUNT_DOWN len=3 -> q_i 0000, 1111, 1110 (wrap); with JKB_SAT_EN: stops at 0000, done with sat=1 after 1 step.
5. TOGGLE mask 0110 on Q=1010 -> Q=1100; PRESET -> Q=1111; HOLD len=0 -> done the cycle after accept, Q unchanged.
6. Assert clr during COUNT_UP len=200 at step 10 -> all controls 0 immediately, busy stays high through INIT, clr_o=1111 one cycle, then IDLE; cmd_valid during busy is not accepted.
